// File: rtl/decoder_recovery_ctrl.sv
// decoder_recovery_ctrl
//   Supervises the stall watchdogs of the ITCH decoder bank. Rising edges of
//   each decoder's stuck_flag are latched as pending recovery requests. One
//   shared flush/resync path is granted round-robin to one decoder at a time.
//   The controller pulses flush to that decoder, waits for it to go idle,
//   counts successful recoveries and raises a sticky timeout error if the
//   decoder never idles.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   stuck_flag     per-decoder stall flag (level)
//   dec_idle       per-decoder idle indication
//   err_clear      single-cycle pulse clearing timeout_err
//   flush          one-hot flush request to the decoder in service (or zero)
//   flush_busy     high while a recovery is in progress (state != IDLE)
//   flush_id       index of the decoder in service, held while idle
//   recover_count  saturating count of successful recoveries
//   timeout_err    sticky: a decoder failed to idle in time
module decoder_recovery_ctrl #(
  parameter int NUM_DEC        = 4,
  parameter int FLUSH_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COOL_CYCLES    = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DEC-1:0]         stuck_flag,
  input  logic [NUM_DEC-1:0]         dec_idle,
  input  logic                       err_clear,
  output logic [NUM_DEC-1:0]         flush,
  output logic                       flush_busy,
  output logic [$clog2(NUM_DEC)-1:0] flush_id,
  output logic [CNT_WIDTH-1:0]       recover_count,
  output logic                       timeout_err
);

  localparam int ID_W   = $clog2(NUM_DEC);
  localparam int MAX_FT = (FLUSH_CYCLES > TIMEOUT_CYCLES) ? FLUSH_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_C  = (MAX_FT > COOL_CYCLES) ? MAX_FT : COOL_CYCLES;
  localparam int TMR_W  = $clog2(MAX_C + 1);

  localparam logic [TMR_W-1:0] FLUSH_LOAD = TMR_W'(FLUSH_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] COOL_LOAD  = TMR_W'(COOL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_WAIT_IDLE,
    S_COOLDOWN
  } state_t;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [ID_W-1:0]      flush_id_q, flush_id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_DEC-1:0]   pending_q, pending_d;
  logic [NUM_DEC-1:0]   stuck_q;
  logic [NUM_DEC-1:0]   flush_q, flush_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 err_q, err_d;

  logic [NUM_DEC-1:0]   rise;
  logic [NUM_DEC-1:0]   svc_mask;
  logic [NUM_DEC-1:0]   grant_mask;
  logic [ID_W:0]        pick;
  logic                 done;
  logic                 err_set;

  function automatic logic [NUM_DEC-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [NUM_DEC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Returns {found, index} of the first request at or above ptr, wrapping.
  // Scanning offsets from highest to lowest lets the nearest one win.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_DEC-1:0] req,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0]   r;
    logic [ID_W-1:0] ii;
    r = '0;
    for (int k = NUM_DEC - 1; k >= 0; k--) begin
      ii = ID_W'((int'(ptr) + k) % NUM_DEC);
      if (req[ii]) r = {1'b1, ii};
    end
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_DEC - 1)) ? '0 : id + ID_W'(1);
  endfunction

  assign rise = stuck_flag & ~stuck_q;
  assign pick = rr_pick(pending_q, rr_ptr_q);
  assign done = dec_idle[flush_id_q] & ~stuck_flag[flush_id_q];
  // A re-stall of the decoder already being flushed is part of the same event.
  assign svc_mask = ((state_q == S_FLUSH) || (state_q == S_WAIT_IDLE)) ? onehot(flush_id_q) : '0;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    flush_id_d = flush_id_q;
    rr_ptr_d   = rr_ptr_q;
    count_d    = count_q;
    flush_d    = '0;
    grant_mask = '0;
    err_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick[ID_W]) begin
          flush_id_d = pick[ID_W-1:0];
          grant_mask = onehot(pick[ID_W-1:0]);
          flush_d    = onehot(pick[ID_W-1:0]);
          timer_d    = FLUSH_LOAD;
          state_d    = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (timer_q == '0) begin
          timer_d = WAIT_LOAD;
          state_d = S_WAIT_IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
          flush_d = onehot(flush_id_q);
        end
      end
      S_WAIT_IDLE: begin
        // Done is checked first so a decoder idling on the last cycle counts.
        if (done || (timer_q == '0)) begin
          if (done) count_d = sat_inc(count_q);
          else      err_set = 1'b1;
          timer_d  = COOL_LOAD;
          rr_ptr_d = next_ptr(flush_id_q);
          state_d  = S_COOLDOWN;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_COOLDOWN: begin
        if (timer_q == '0) state_d = S_IDLE;
        else               timer_d = timer_q - TMR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    pending_d = (pending_q & ~grant_mask) | (rise & ~svc_mask);
    err_d     = err_set ? 1'b1 : (err_clear ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      flush_id_q <= '0;
      rr_ptr_q   <= '0;
      pending_q  <= '0;
      stuck_q    <= '0;
      flush_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      flush_id_q <= flush_id_d;
      rr_ptr_q   <= rr_ptr_d;
      pending_q  <= pending_d;
      stuck_q    <= stuck_flag;
      flush_q    <= flush_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  assign flush         = flush_q;
  assign flush_busy    = (state_q != S_IDLE);
  assign flush_id      = flush_id_q;
  assign recover_count = count_q;
  assign timeout_err   = err_q;

endmodule

// File: doc/decoder_recovery_ctrl.md
Name: decoder_recovery_ctrl

Overview:
- Supervises the per-decoder stall watchdogs of the ITCH decoder bank (one `stuck_flag` per decoder).
- Latches stall events and grants the single shared flush/resync path to one decoder at a time, round-robin.
- Drives a flush pulse to that decoder, waits for it to go idle, then reports a recovery count and a sticky timeout error.
- Sits between the decoder array and the top-level status/CSR logic.

Parameters:
- NUM_DEC, 4, number of decoders supervised (≥2).
- FLUSH_CYCLES, 2, cycles `flush` is held high per recovery (≥1).
- TIMEOUT_CYCLES, 16, max cycles to wait for the decoder to idle after flush (≥1).
- COOL_CYCLES, 1, guard cycles after each recovery before the next grant (≥1).
- CNT_WIDTH, 16, width of the recovery counter.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stuck_flag  in  NUM_DEC  per-decoder watchdog stall flag (level).
- dec_idle  in  NUM_DEC  per-decoder idle (`is_active` low).
- err_clear  in  1  clears `timeout_err` (single-cycle pulse).
- flush  out  NUM_DEC  one-hot flush request to the selected decoder.
- flush_busy  out  1  high whenever state ≠ IDLE.
- flush_id  out  $clog2(NUM_DEC)  index of the decoder in service; holds its last value in IDLE.
- recover_count  out  CNT_WIDTH  successful recoveries, saturating.
- timeout_err  out  1  sticky: a decoder failed to idle within TIMEOUT_CYCLES.

Behaviour:
- Reset (async, immediate):
  - `flush` = 0, `flush_busy` = 0, `flush_id` = 0, `recover_count` = 0, `timeout_err` = 0.
  - `pending` = 0, `stuck_q` = 0, `rr_ptr` = 0, timer = 0, state = IDLE.
  - Reset mid-FLUSH drops `flush` without waiting for a clock.
- Event capture:
  - `stuck_q` registers `stuck_flag` every cycle.
  - A rising edge (`stuck_flag[i]` & ~`stuck_q[i]`) sets `pending[i]`.
  - A level held high does not re-arm.
  - A rising edge on the channel in service during FLUSH or WAIT_IDLE is ignored. Other channels latch normally.
- Arbitration (IDLE only):
  - If `pending` ≠ 0, grant the first set bit searching upward from `rr_ptr`, wrapping modulo NUM_DEC.
  - On grant: register `flush_id`, clear that `pending` bit, load timer = FLUSH_CYCLES-1, go to FLUSH.
  - Latency: `stuck_flag[i]` first sampled high at edge k → `pending[i]` after edge k → `flush[i]` high after edge k+1 (with the controller idle).
- FLUSH:
  - `flush` = one-hot(`flush_id`), registered, for exactly FLUSH_CYCLES cycles.
  - When timer = 0: load timer = TIMEOUT_CYCLES-1, go to WAIT_IDLE.
- WAIT_IDLE:
  - `flush` = 0. Done when `dec_idle[flush_id]` = 1 and `stuck_flag[flush_id]` = 0.
  - On done: `recover_count` += 1, saturating at all-ones.
  - Else if timer = 0: set `timeout_err`; `recover_count` is not incremented.
  - Otherwise decrement the timer.
  - On done or timeout: load timer = COOL_CYCLES-1, go to COOLDOWN.
  - If done and timer = 0 occur together, done wins.
- COOLDOWN:
  - Counts COOL_CYCLES, then returns to IDLE.
  - `rr_ptr` = (`flush_id`+1) mod NUM_DEC, updated on entry.
  - New events during COOLDOWN latch into `pending`.
- `timeout_err`: set has priority over `err_clear` in the same cycle. Otherwise `err_clear` = 1 clears it.
- Only one decoder is ever flushed at a time: `flush` is one-hot or zero (bench assertion).
- Timer width: $clog2(max(FLUSH_CYCLES, TIMEOUT_CYCLES, COOL_CYCLES)+1).

Test Plan:
- Single event, defaults: rising `stuck_flag[2]`, `dec_idle[2]` high 3 cycles after flush ends → `flush` = 4'b0100 for 2 cycles starting 2 cycles after the edge, `flush_id` = 2, `recover_count` = 1, `flush_busy` low after 1 cooldown cycle.
- Simultaneous events: `stuck_flag` 4'b1011 rising in one cycle with `rr_ptr` = 0, all decoders idle promptly → service order 0, 1, 3; `recover_count` = 3; never more than one `flush` bit high.
- Timeout: `stuck_flag[1]` rises, `dec_idle[1]` held low → after 2 flush + 16 wait cycles `timeout_err` = 1, `recover_count` unchanged. Then `err_clear` pulse → `timeout_err` = 0. `err_clear` coincident with a second timeout → `timeout_err` stays 1.
- Held level / re-arm: `stuck_flag[0]` held high 40 cycles → exactly one grant. Toggling it low then high after recovery → a second grant.
- Saturation: CNT_WIDTH = 2, 5 successful recoveries → `recover_count` = 3.
- Reset mid-FLUSH: assert `rst` between clock edges during FLUSH → `flush` = 0 and `flush_busy` = 0 immediately. `pending` cleared, so no grant after release until a new rising edge.
